// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, constants and helpers for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    // Port that wins when both write ports target the same entry
    localparam int WR_PRIO_PORT = 1;

    // Address width for a given depth; never narrower than one bit
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - clear sequencer walking the array one entry per cycle
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    // State and counter registers; reset restarts the sweep from entry 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: sweep every entry, then idle until another clear is requested
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        busy     = 1'b0;
        case (state)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nx = READY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            READY: begin
                if (clear_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = '0;
            end
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, two prioritised writes, optional parity via REGFILE_PARITY_EN
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear_req,
    output logic                    busy,
    input  logic [1:0]              wr_en,
    input  logic [2*AW-1:0]         wr_addr,
    input  logic [2*WIDTH-1:0]      wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
`ifdef REGFILE_PARITY_EN
    input  logic                    perr_inject,
    output logic [NUM_RD-1:0]       rd_perr,
`endif
    output logic [NUM_RD*WIDTH-1:0] rd_data
);

    localparam int HI = WR_PRIO_PORT;
    localparam int LO = 1 - WR_PRIO_PORT;

    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wa [2];
    logic [WIDTH-1:0] wd [2];
    logic [1:0]       wr_live;

    regfile_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // A write port is live only outside the clear sweep and never to a hardwired zero entry
    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign wa[p]      = wr_addr[p*AW +: AW];
        assign wd[p]      = wr_data[p*WIDTH +: WIDTH];
        assign wr_live[p] = wr_en[p] && !busy && !((ZERO_REG != 0) && (wa[p] == '0));
    end

    // Array update: the clear write owns the array; otherwise the priority port is applied last
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr_live[LO]) mem[wa[LO]] <= wd[LO];
            if (wr_live[HI]) mem[wa[HI]] <= wd[HI];
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_mem [DEPTH];
    logic wp [2];

    // Even parity of the write data; the inject input corrupts port 0's stored bit
    assign wp[0] = (^wd[0]) ^ perr_inject;
    assign wp[1] = ^wd[1];

    // Parity storage follows the data array write-for-write
    always_ff @(posedge clock) begin
        if (clr_we) begin
            par_mem[clr_addr] <= 1'b0;
        end else begin
            if (wr_live[LO]) par_mem[wa[LO]] <= wp[LO];
            if (wr_live[HI]) par_mem[wa[HI]] <= wp[HI];
        end
    end
`endif

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rv;
        logic             byp_hit;
        logic             zero_hit;

        assign ra       = rd_addr[i*AW +: AW];
        assign byp_hit  = (BYPASS != 0) &&
                          ((wr_live[0] && (wa[0] == ra)) || (wr_live[1] && (wa[1] == ra)));
        assign zero_hit = (ZERO_REG != 0) && (ra == '0);

        // Read mux: stored value, overridden by same-cycle write data with port priority
        always_comb begin
            rv = mem[ra];
            if (BYPASS != 0) begin
                if (wr_live[LO] && (wa[LO] == ra)) rv = wd[LO];
                if (wr_live[HI] && (wa[HI] == ra)) rv = wd[HI];
            end
            if (busy || zero_hit) rv = '0;
        end

        assign rd_data[i*WIDTH +: WIDTH] = rv;

`ifdef REGFILE_PARITY_EN
        // Parity check applies only to reads served from the array itself
        always_comb begin
            rd_perr[i] = (^mem[ra]) ^ par_mem[ra];
            if (busy || zero_hit || byp_hit) rd_perr[i] = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with directed vectors
module tb_regfile_mp;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;
    localparam int BYPASS   = 1;
    localparam int AW       = 5;

    logic                    clock;
    logic                    reset;
    logic                    clear_req;
    logic                    busy;
    logic [1:0]              wr_en;
    logic [2*AW-1:0]         wr_addr;
    logic [2*WIDTH-1:0]      wr_data;
    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
`ifdef REGFILE_PARITY_EN
    logic                    perr_inject;
    logic [NUM_RD-1:0]       rd_perr;
`endif

    regfile_mp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
`ifdef REGFILE_PARITY_EN
        .perr_inject (perr_inject),
        .rd_perr     (rd_perr),
`endif
        .rd_data   (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
        logic [31:0] act;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_rd(input string nm, input int port, input logic [31:0] e);
        sb.push_back('{nm, 0, port, e, 32'h0});
    endtask

    task automatic expect_busy(input string nm, input logic e);
        sb.push_back('{nm, 1, 0, {31'b0, e}, 32'h0});
    endtask

    task automatic expect_perr(input string nm, input int port, input logic e);
        sb.push_back('{nm, 2, port, {31'b0, e}, 32'h0});
    endtask

    task automatic expect_val(input string nm, input int act, input int e);
        sb.push_back('{nm, 3, 0, e, act});
    endtask

    // Monitor: outputs are settled mid-cycle; drain everything the stimulus queued
    always @(negedge clock) begin
        chk_t        c;
        logic [31:0] a;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
                0:       a = rd_data[c.idx*WIDTH +: WIDTH];
                1:       a = {31'b0, busy};
`ifdef REGFILE_PARITY_EN
                2:       a = {31'b0, rd_perr[c.idx]};
`endif
                default: a = c.act;
            endcase
            checks++;
            if (a !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input int a0, input logic [31:0] d0,
                          input int a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {AW'(a1), AW'(a0)};
        wr_data = {d1, d0};
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset     = 1'b1;
        clear_req = 1'b0;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(0, 0);
`ifdef REGFILE_PARITY_EN
        perr_inject = 1'b0;
`endif
        tick;
        tick;
        set_rd(3, 0);
        expect_busy("busy_in_reset", 1'b1);
        expect_rd("rd0_in_reset", 0, 32'h0);
        expect_rd("rd1_in_reset", 1, 32'h0);
        tick;

        // Initial clear after reset release
        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            set_rd(n % 32, (n + 7) % 32);
            expect_rd("rd_during_init_clear", 0, 32'h0);
            tick;
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_clear_len_direct: got %0d expected %0d", n, DEPTH);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_low_after_init_direct: got %b", busy);
        end
        expect_val("init_clear_len", n, DEPTH);
        expect_busy("busy_after_init", 1'b0);
        set_rd(5, 31);
        expect_rd("rd_after_init_a", 0, 32'h0);
        expect_rd("rd_after_init_b", 1, 32'h0);
        tick;

        // Same-cycle bypass then stored value
        set_wr(2'b01, 5, 32'hDEADBEEF, 0, 0);
        set_rd(5, 5);
        expect_rd("bypass_same_cycle", 0, BYPASS != 0 ? 32'hDEADBEEF : 32'h0);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        expect_rd("stored_after_edge", 0, 32'hDEADBEEF);
        expect_rd("stored_after_edge_p1", 1, 32'hDEADBEEF);
        tick;

        // Both ports to one address: port 1 wins
        set_wr(2'b11, 7, 32'h11111111, 7, 32'h22222222);
        set_rd(7, 6);
        expect_rd("prio_bypass", 0, BYPASS != 0 ? 32'h22222222 : 32'h0);
        expect_rd("prio_other_entry", 1, 32'h0);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        expect_rd("prio_stored", 0, 32'h22222222);
        tick;

        // Both ports to different addresses
        set_wr(2'b11, 10, 32'hA5A5A5A5, 11, 32'h5A5A5A5A);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(10, 11);
        expect_rd("dual_write_p0", 0, 32'hA5A5A5A5);
        expect_rd("dual_write_p1", 1, 32'h5A5A5A5A);
        tick;

        // Zero register
        set_wr(2'b10, 0, 0, 0, 32'hFFFFFFFF);
        set_rd(0, 0);
        expect_rd("zero_same_cycle", 0,
                  ZERO_REG != 0 ? 32'h0 : (BYPASS != 0 ? 32'hFFFFFFFF : 32'h0));
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        expect_rd("zero_after_edge", 0, ZERO_REG != 0 ? 32'h0 : 32'hFFFFFFFF);
        tick;

        // Fill 1..31 with index and read back
        for (int a = 1; a < 32; a++) begin
            set_wr(2'b01, a, a, 0, 0);
            tick;
        end
        set_wr(2'b00, 0, 0, 0, 0);
        for (int a = 1; a < 32; a++) begin
            set_rd(a, 32 - a);
            expect_rd("fill_readback_p0", 0, a);
            expect_rd("fill_readback_p1", 1, 32 - a);
            tick;
        end

        // Clear request together with a READY write, write during CLEAR, repeated request ignored
        clear_req = 1'b1;
        set_wr(2'b01, 4, 32'h44, 0, 0);
        tick;
        clear_req = 1'b0;
        set_wr(2'b00, 0, 0, 0, 0);
        n = 0;
        while (busy && n < 100) begin
            if (n == 10) set_wr(2'b01, 3, 32'h33, 0, 0);
            else         set_wr(2'b00, 0, 0, 0, 0);
            clear_req = (n == 20);
            set_rd(3, 4);
            expect_rd("rd_during_clear", 0, 32'h0);
            tick;
            n++;
        end
        clear_req = 1'b0;
        set_wr(2'b00, 0, 0, 0, 0);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL req_clear_len_direct: got %0d expected %0d", n, DEPTH);
        end
        expect_val("req_clear_len", n, DEPTH);
        for (int a = 0; a < 32; a += 2) begin
            set_rd(a, a + 1);
            expect_rd("after_clear_p0", 0, 32'h0);
            expect_rd("after_clear_p1", 1, 32'h0);
            tick;
        end

        // Reset in the middle of a clear sweep restarts it
        set_wr(2'b01, 12, 32'h0C, 0, 0);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        clear_req = 1'b1;
        tick;
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick;
        reset = 1'b1;
        #1;
        expect_busy("busy_reset_mid_clear", 1'b1);
        tick;
        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL restart_clear_len_direct: got %0d expected %0d", n, DEPTH);
        end
        expect_val("restart_clear_len", n, DEPTH);
        set_rd(12, 5);
        #1;
        checks++;
        if (rd_data[WIDTH-1:0] !== 32'h0) begin
            errors++;
            $display("FAIL after_restart_12_direct: got %h expected 0", rd_data[WIDTH-1:0]);
        end
        expect_rd("after_restart_12", 0, 32'h0);
        expect_rd("after_restart_5", 1, 32'h0);
        tick;

`ifdef REGFILE_PARITY_EN
        set_wr(2'b01, 9, 32'h00000001, 0, 0);
        perr_inject = 1'b1;
        set_rd(9, 8);
        expect_perr("perr_bypassed", 0, 1'b0);
        expect_perr("perr_clean_entry", 1, 1'b0);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        perr_inject = 1'b0;
        expect_perr("perr_injected", 0, 1'b1);
        expect_rd("perr_data", 0, 32'h00000001);
        tick;
        set_wr(2'b01, 8, 32'h00000007, 0, 0);
        tick;
        set_wr(2'b00, 0, 0, 0, 0);
        set_rd(8, 0);
        expect_perr("perr_good_write", 0, 1'b0);
        expect_perr("perr_zero_reg", 1, 1'b0);
        tick;
`endif

        tick;
        @(negedge clock);
        #1;
        if (errors != 0 || checks < 12) $display("FAIL summary");
        else                            $display("PASS");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
